// File: rtl/fcu_result_stage.sv
// Result stage behind the FCU calc bus: classifies RET mispredicts and BRK
// exceptions, queues results, and squashes younger results after a delivered miss.
module fcu_result_stage #(
  parameter int WID   = 52,
  parameter int AMSB  = 51,
  parameter int RBIT  = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [RBIT-1:0] in_rid_i,
  input  logic [1:0]      in_kind_i,
  input  logic [WID-1:0]  in_bus_i,
  input  logic [AMSB:0]   in_predpc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [RBIT-1:0] out_rid_o,
  output logic [WID-1:0]  out_res_o,
  output logic            out_miss_o,
  output logic [AMSB:0]   out_misspc_o,
  output logic            out_exc_o,
  output logic [31:0]     miss_cnt_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] K_RET = 2'd1;
  localparam logic [1:0] K_BRK = 2'd3;
  localparam logic [WID-1:0] BRK_RES = WID'({((WID + 3) / 4){4'hC}});

  typedef struct packed {
    logic [RBIT-1:0] rid;
    logic [WID-1:0]  res;
    logic            miss;
    logic [AMSB:0]   misspc;
    logic            exc;
  } ent_t;

  typedef enum logic {RUN, SQUASH} st_e;

  st_e         st;
  ent_t        mem [DEPTH];
  ent_t        nent, head;
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic        push, pop, miss_pop, mem_we;
  logic [31:0] miss_nxt;

  assign in_ready_o  = (st == SQUASH) || (cnt != (PW+1)'(DEPTH));
  assign out_valid_o = (st == RUN) && (cnt != '0);
  assign head        = mem[rp];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign miss_pop    = pop && head.miss;
  // Writes are dropped while squashing, on flush, and on the edge a miss leaves.
  assign mem_we      = push && !flush_i && (st == RUN) && !miss_pop;
  assign miss_nxt    = (miss_pop && miss_cnt_o != 32'hFFFF_FFFF) ? miss_cnt_o + 32'd1 : miss_cnt_o;

  always_comb begin
    nent     = '0;
    nent.rid = in_rid_i;
    nent.res = in_bus_i;
    case (in_kind_i)
      K_RET: begin
        nent.miss   = (in_bus_i[AMSB:0] != in_predpc_i);
        nent.misspc = in_bus_i[AMSB:0];
      end
      K_BRK: begin
        nent.res = BRK_RES;
        nent.exc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wp] <= nent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st         <= RUN;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      miss_cnt_o <= '0;
    end else begin
      miss_cnt_o <= miss_nxt;
      if (flush_i || (st == RUN && miss_pop)) begin
        st  <= flush_i ? RUN : SQUASH;
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (st == RUN) begin
        if (mem_we) wp <= wp + PW'(1);
        if (pop)    rp <= rp + PW'(1);
        if (mem_we && !pop)      cnt <= cnt + (PW+1)'(1);
        else if (pop && !mem_we) cnt <= cnt - (PW+1)'(1);
      end
    end
  end

  assign out_rid_o    = out_valid_o ? head.rid    : '0;
  assign out_res_o    = out_valid_o ? head.res    : '0;
  assign out_miss_o   = out_valid_o ? head.miss   : 1'b0;
  assign out_misspc_o = out_valid_o ? head.misspc : '0;
  assign out_exc_o    = out_valid_o ? head.exc    : 1'b0;
endmodule

// File: tb/tb_fcu_result_stage.sv
// Directed plus randomized checks of fcu_result_stage against a queue-based model.
module tb_fcu_result_stage;
  localparam int DEPTH = 2;
  localparam logic [1:0] OTH = 2'd0, RET = 2'd1, JAL = 2'd2, BRK = 2'd3;

  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [3:0]  in_rid_i = '0;
  logic [1:0]  in_kind_i = '0;
  logic [51:0] in_bus_i = '0, in_predpc_i = '0;
  logic        out_valid_o, out_ready_i = 1'b0;
  logic [3:0]  out_rid_o;
  logic [51:0] out_res_o, out_misspc_o;
  logic        out_miss_o, out_exc_o;
  logic [31:0] miss_cnt_o;

  int checks = 0;
  int errors = 0;

  fcu_result_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rid_i(in_rid_i),
    .in_kind_i(in_kind_i), .in_bus_i(in_bus_i), .in_predpc_i(in_predpc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rid_o(out_rid_o),
    .out_res_o(out_res_o), .out_miss_o(out_miss_o), .out_misspc_o(out_misspc_o),
    .out_exc_o(out_exc_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  rid;
    logic [51:0] res;
    logic        miss;
    logic [51:0] misspc;
    logic        exc;
  } ent_t;

  ent_t        q[$];
  bit          sq;
  logic [31:0] mcnt;

  function automatic ent_t classify(logic [1:0] k, logic [3:0] rid, logic [51:0] bus, logic [51:0] pred);
    ent_t e;
    e.rid = rid; e.res = bus; e.miss = 1'b0; e.misspc = '0; e.exc = 1'b0;
    if (k == RET) begin
      e.miss = (bus != pred);
      e.misspc = bus;
    end else if (k == BRK) begin
      e.res = 52'hCCCCCCCCCCCCC;
      e.exc = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit v;
    ent_t h;
    v = !sq && q.size() > 0;
    h = classify(OTH, 4'd0, 52'd0, 52'd0);
    if (v) h = q[0];
    chk({tag, ".valid"}, 64'(out_valid_o), 64'(v));
    chk({tag, ".ready"}, 64'(in_ready_o), 64'(sq || q.size() < DEPTH));
    chk({tag, ".rid"}, 64'(out_rid_o), 64'(h.rid));
    chk({tag, ".res"}, 64'(out_res_o), 64'(h.res));
    chk({tag, ".miss"}, 64'(out_miss_o), 64'(h.miss));
    chk({tag, ".misspc"}, 64'(out_misspc_o), 64'(h.misspc));
    chk({tag, ".exc"}, 64'(out_exc_o), 64'(h.exc));
    chk({tag, ".mcnt"}, 64'(miss_cnt_o), 64'(mcnt));
  endtask

  // One clock of the reference behaviour, using the inputs held across the edge.
  task automatic model_edge();
    bit rdy, v, push, pop, hmiss;
    rdy   = sq || q.size() < DEPTH;
    v     = !sq && q.size() > 0;
    push  = in_valid_i && rdy;
    pop   = v && out_ready_i;
    hmiss = pop && q[0].miss;
    if (hmiss && mcnt != 32'hFFFFFFFF) mcnt = mcnt + 1;
    if (flush_i) begin
      q.delete(); sq = 0;
    end else if (!sq) begin
      if (hmiss) begin
        q.delete(); sq = 1;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(classify(in_kind_i, in_rid_i, in_bus_i, in_predpc_i));
      end
    end
  endtask

  task automatic step(input string tag, input logic iv, input logic [1:0] k, input logic [3:0] rid,
                      input logic [51:0] bus, input logic [51:0] pred, input logic ordy, input logic fl);
    in_valid_i = iv; in_kind_i = k; in_rid_i = rid; in_bus_i = bus; in_predpc_i = pred;
    out_ready_i = ordy; flush_i = fl;
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all(tag);
  endtask

  initial begin
    logic [63:0] rb;
    logic [51:0] b, p;
    sq = 0; mcnt = '0;
    repeat (2) @(negedge clk_i);
    check_all("rst");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_all("rst_rel");

    // Correctly predicted RET
    step("t1", 1, RET, 4'd0, 52'h100, 52'h100, 1, 0);
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_res", 64'(out_res_o), 64'h100);
    chk("t1_miss", 64'(out_miss_o), 64'd0);
    step("t1_drain", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);

    // Mispredicted RET squashes the younger JAL
    step("t2a", 1, RET, 4'd1, 52'h200, 52'h204, 0, 0);
    step("t2b", 1, JAL, 4'd5, 52'h404, 52'd0, 0, 0);
    chk("t2_miss", 64'(out_miss_o), 64'd1);
    chk("t2_misspc", 64'(out_misspc_o), 64'h200);
    step("t2c", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("t2_sq_valid", 64'(out_valid_o), 64'd0);
    chk("t2_mcnt", 64'(miss_cnt_o), 64'd1);
    step("t2d", 1, JAL, 4'd7, 52'h408, 52'd0, 1, 0);
    step("t2e", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("t2_nojal", 64'(out_valid_o), 64'd0);
    step("t2f", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 1);
    step("t2g", 1, JAL, 4'd6, 52'h500, 52'd0, 1, 0);
    chk("t2_jal_rid", 64'(out_rid_o), 64'd6);
    chk("t2_jal_res", 64'(out_res_o), 64'h500);
    step("t2h", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);

    // BRK forces the result pattern
    step("t3", 1, BRK, 4'd2, 52'd0, 52'd0, 1, 0);
    chk("t3_exc", 64'(out_exc_o), 64'd1);
    chk("t3_res", 64'(out_res_o), 64'hCCCCCCCCCCCCC);
    step("t3_drain", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);

    // Full FIFO back-pressure, ordered drain, pointer wrap
    step("t4a", 1, OTH, 4'd0, 52'h10, 52'd0, 0, 0);
    step("t4b", 1, OTH, 4'd1, 52'h11, 52'd0, 0, 0);
    chk("t4_full_ready", 64'(in_ready_o), 64'd0);
    step("t4c", 1, OTH, 4'd2, 52'h12, 52'd0, 0, 0);
    chk("t4_head0", 64'(out_rid_o), 64'd0);
    step("t4d", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("t4_head1", 64'(out_rid_o), 64'd1);
    step("t4e", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("t4_empty", 64'(out_valid_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step("t4wrap", 1, JAL, 4'(i), 52'(i + 32), 52'd0, 1, 0);
      chk("t4_wrap_rid", 64'(out_rid_o), 64'(i));
    end
    step("t4f", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);

    // Flush coincident with a push
    step("t5a", 1, OTH, 4'd3, 52'h33, 52'd0, 0, 0);
    step("t5b", 1, OTH, 4'd4, 52'h44, 52'd0, 0, 1);
    chk("t5_flushed", 64'(out_valid_o), 64'd0);
    step("t5c", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("t5_never", 64'(out_valid_o), 64'd0);

    // Counter saturation
    force dut.miss_cnt_o = 32'hFFFFFFFE;
    mcnt = 32'hFFFFFFFE;
    step("t6f", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    release dut.miss_cnt_o;
    for (int i = 0; i < 3; i++) begin
      step("t6a", 1, RET, 4'(i), 52'h700, 52'h704, 1, 0);
      step("t6b", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
      step("t6c", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 1);
    end
    chk("t6_sat", 64'(miss_cnt_o), 64'hFFFFFFFF);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rb = {$urandom(), $urandom()};
      b = rb[51:0];
      p = ($urandom_range(0, 1) == 0) ? b : (b ^ (52'd1 << $urandom_range(0, 51)));
      step("rnd", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           b, p, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // Reset in the middle of traffic
    step("mr_a", 1, OTH, 4'd9, 52'h99, 52'd0, 0, 0);
    step("mr_b", 1, OTH, 4'd10, 52'h9A, 52'd0, 0, 0);
    #2 rst_ni = 1'b0;
    q.delete(); sq = 0; mcnt = '0;
    in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b0;
    #1 check_all("mr_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("mr_c", 0, OTH, 4'd0, 52'd0, 52'd0, 1, 0);
    chk("mr_empty", 64'(out_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
